// File: rtl/avm_initiator_arbiter_pkg.sv
// avm_arb_pkg: shared types and helpers for the Avalon-MM initiator arbiter.
//   arb_state_e : arbiter FSM state (idle / a requester owns the port)
//   rr_pick()   : round-robin search returning {found, idx}
package avm_arb_pkg;

  // Widest requester count the helper function supports.
  localparam int MAX_NREQ = 8;
  localparam int MAX_IW   = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Search last+1, last+2, ... (mod nreq) for the first set cmd bit,
  // optionally skipping exclude_idx. The final probe (k == nreq) lands on
  // 'last' itself, so a lone requester can win again after a release.
  function automatic logic [MAX_IW:0] rr_pick(
    input logic [MAX_NREQ-1:0] cmd,
    input logic [MAX_IW-1:0]   last,
    input logic                exclude_valid,
    input logic [MAX_IW-1:0]   exclude_idx,
    input int                  nreq
  );
    logic [MAX_IW:0] res;
    int              j;
    res = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      j = (int'(last) + k) % nreq;
      if (k <= nreq && !res[MAX_IW] && cmd[j] &&
          !(exclude_valid && exclude_idx == MAX_IW'(j)))
        res = {1'b1, MAX_IW'(j)};
    end
    return res;
  endfunction

endpackage

// File: rtl/avm_initiator_arbiter_if.sv
// avm_initiator_arbiter_if: bundles the per-requester initiator ports and the
// shared Avalon-MM initiator port.
//   req_*   : NREQ private initiator interfaces (commands in, stall/data out)
//   avm_*   : single shared initiator port toward the interconnect
//   grant   : one-hot current owner, zero when idle
// Modports: slave = arbiter view, master = requesters + fabric view.
interface avm_initiator_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]       req_read;
  logic [NREQ-1:0]       req_write;
  logic [NREQ-1:0][31:0] req_address;
  logic [NREQ-1:0][31:0] req_writedata;
  logic [NREQ-1:0]       req_waitrequest;
  logic [31:0]           req_readdata;

  logic                  avm_read;
  logic                  avm_write;
  logic [31:0]           avm_address;
  logic [31:0]           avm_writedata;
  logic                  avm_waitrequest;
  logic [31:0]           avm_readdata;

  logic [NREQ-1:0]       grant;

  modport slave (
    input  req_read, req_write, req_address, req_writedata,
    input  avm_waitrequest, avm_readdata,
    output req_waitrequest, req_readdata,
    output avm_read, avm_write, avm_address, avm_writedata,
    output grant
  );

  modport master (
    output req_read, req_write, req_address, req_writedata,
    output avm_waitrequest, avm_readdata,
    input  req_waitrequest, req_readdata,
    input  avm_read, avm_write, avm_address, avm_writedata,
    input  grant
  );
endinterface

// File: rtl/avm_initiator_arbiter_rr_picker.sv
// rr_picker: combinational rotate-and-priority-encode over NREQ commands.
//   cmd_i         : per-requester command
//   last_i        : search starts at last_i+1
//   excl_valid_i  : skip excl_idx_i in the search
//   excl_idx_i    : index to skip
//   found_o/idx_o : a winner exists / its index
module rr_picker
  import avm_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] cmd_i,
  input  logic [IW-1:0]   last_i,
  input  logic            excl_valid_i,
  input  logic [IW-1:0]   excl_idx_i,
  output logic            found_o,
  output logic [IW-1:0]   idx_o
);
  logic [MAX_NREQ-1:0] cmd_pad;
  logic [MAX_IW:0]     res;

  assign cmd_pad = MAX_NREQ'(cmd_i);
  assign res     = rr_pick(cmd_pad, MAX_IW'(last_i), excl_valid_i,
                           MAX_IW'(excl_idx_i), NREQ);
  assign found_o = res[MAX_IW];
  assign idx_o   = IW'(res[MAX_IW-1:0]);
endmodule

// File: rtl/avm_initiator_arbiter.sv
// avm_initiator_arbiter: round-robin sharing of one Avalon-MM initiator port
// between NREQ requesters, holding the grant for up to MAX_HOLD completed
// transfers while others wait.
//   clk, reset : clock, synchronous active-high reset
//   bus        : avm_initiator_arbiter_if.slave (requester + shared ports)
module avm_initiator_arbiter
  import avm_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_HOLD = 2,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int HW      = $clog2(MAX_HOLD + 1)
) (
  input logic                    clk,
  input logic                    reset,
  avm_initiator_arbiter_if.slave bus
);
  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q,  last_d;
  logic [HW-1:0]   hold_q,  hold_d;

  logic [NREQ-1:0] cmd;
  logic [NREQ-1:0] owner_oh;
  logic            own_cmd;
  logic            others;
  logic            own_act;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   pick_last;

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] req_wait;
  logic            avm_rd, avm_wr;
  logic [31:0]     avm_addr, avm_wd;

  assign cmd      = bus.req_read | bus.req_write;
  assign owner_oh = NREQ'(1) << owner_q;
  assign own_cmd  = cmd[owner_q];
  assign others   = |(cmd & ~owner_oh);
  // Outputs are forced quiet while reset is high, so the port is already
  // released in the reset cycle even though the state is still OWN.
  assign own_act  = (state_q == ARB_OWN) && !reset;

  // While owning, search starts after the owner: on quantum expiry that is
  // the required exclusion, and on release last becomes owner anyway. The
  // owner's cmd is low on release, so excluding it changes nothing there.
  assign pick_last = (state_q == ARB_OWN) ? owner_q : last_q;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .cmd_i        (cmd),
    .last_i       (pick_last),
    .excl_valid_i (state_q == ARB_OWN),
    .excl_idx_i   (owner_q),
    .found_o      (pick_found),
    .idx_o        (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|cmd) begin
          owner_d = pick_idx;
          hold_d  = '0;
          state_d = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (!own_cmd) begin
          last_d = owner_q;
          hold_d = '0;
          if (pick_found) owner_d = pick_idx;
          else            state_d = ARB_IDLE;
        end else if (!bus.avm_waitrequest) begin
          if (!others) begin
            hold_d = '0;               // nobody waiting: keep grant, fresh quantum
          end else if (hold_q + HW'(1) == HW'(MAX_HOLD)) begin
            last_d  = owner_q;
            owner_d = pick_idx;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        // owner stalled: hold everything, never revoke mid-transfer
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant    = '0;
    req_wait = '1;
    avm_rd   = 1'b0;
    avm_wr   = 1'b0;
    avm_addr = '0;
    avm_wd   = '0;
    if (own_act) begin
      grant[owner_q]    = 1'b1;
      req_wait[owner_q] = bus.avm_waitrequest;
      avm_rd            = bus.req_read[owner_q];
      avm_wr            = bus.req_write[owner_q];
      avm_addr          = bus.req_address[owner_q];
      avm_wd            = bus.req_writedata[owner_q];
    end
  end

  assign bus.grant           = grant;
  assign bus.req_waitrequest = req_wait;
  assign bus.req_readdata    = bus.avm_readdata;
  assign bus.avm_read        = avm_rd;
  assign bus.avm_write       = avm_wr;
  assign bus.avm_address     = avm_addr;
  assign bus.avm_writedata   = avm_wd;
endmodule
